// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load,
// all-zero lockup recovery and period tracking.
module lfsr_gen #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] FTAPS  = 8'h8E,
  parameter logic [WIDTH-1:0] GMASK  = 8'h1D,
  parameter logic [WIDTH-1:0] SEED   = 8'hBD,
  parameter bit               GALOIS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] out,
  output logic             bit_out,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             lockup
);

  // A zero seed would recover straight back into lockup.
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be nonzero");
  end
  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be 3..32");
  end

  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] nxt;
  logic             fb;
  logic             zero;

  assign zero    = (out == '0);
  assign bit_out = out[WIDTH-1];

  // Next state for the selected LFSR form.
  always_comb begin
    fb  = ^(out & FTAPS);
    nxt = '0;
    if (GALOIS) begin
      nxt = {out[WIDTH-2:0], 1'b0}
          ^ ({WIDTH{out[WIDTH-1]}} & GMASK);
    end else begin
      nxt = {out[WIDTH-2:0], fb};
    end
  end

  // State, period start, step count and pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out    <= SEED;
      start  <= SEED;
      cnt    <= '0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else if (load) begin
      out    <= seed_in;
      start  <= seed_in;
      cnt    <= '0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else if (zero) begin
      out    <= SEED;
      start  <= SEED;
      cnt    <= '0;
      wrap   <= 1'b0;
      lockup <= 1'b1;
    end else if (en) begin
      out    <= nxt;
      lockup <= 1'b0;
      if (nxt == start) begin
        wrap <= 1'b1;
        cnt  <= '0;
      end else begin
        wrap <= 1'b0;
        cnt  <= cnt + WIDTH'(1);
      end
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: both LFSR forms driven in
// lockstep against a cycle model via a scoreboard.
module tb_lfsr_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [7:0] seed_in;

  logic [7:0] f_out, f_cnt, g_out, g_cnt;
  logic       f_bit, f_wrap, f_lock;
  logic       g_bit, g_wrap, g_lock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] out[2];
    logic [7:0] cnt[2];
    logic       wrap[2];
    logic       lock[2];
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] m_out[2];
  logic [7:0] m_start[2];
  logic [7:0] m_cnt[2];
  logic       m_wrap[2];
  logic       m_lock[2];

  lfsr_gen #(
    .WIDTH(8), .FTAPS(8'h8E), .GMASK(8'h1D),
    .SEED(8'hBD), .GALOIS(1'b0)
  ) u_fib (
    .clk(clk), .rst_n(rst_n), .en(en),
    .load(load), .seed_in(seed_in),
    .out(f_out), .bit_out(f_bit), .cnt(f_cnt),
    .wrap(f_wrap), .lockup(f_lock)
  );

  lfsr_gen #(
    .WIDTH(8), .FTAPS(8'h8E), .GMASK(8'h1D),
    .SEED(8'hBD), .GALOIS(1'b1)
  ) u_gal (
    .clk(clk), .rst_n(rst_n), .en(en),
    .load(load), .seed_in(seed_in),
    .out(g_out), .bit_out(g_bit), .cnt(g_cnt),
    .wrap(g_wrap), .lockup(g_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // x^8+x^4+x^3+x^2+1, Fibonacci: feedback from bits 7,3,2,1
  function automatic logic [7:0] fib_next(input logic [7:0] s);
    logic f;
    f = s[7] ^ s[3] ^ s[2] ^ s[1];
    return {s[6:0], f};
  endfunction

  function automatic logic [7:0] gal_next(input logic [7:0] s);
    logic [7:0] t;
    t = s << 1;
    if (s[7]) t = t ^ 8'h1D;
    return t;
  endfunction

  task automatic drive(input logic r, input logic l,
                       input logic e, input logic [7:0] s);
    exp_t x;
    logic [7:0] n;
    @(negedge clk);
    rst_n = r; load = l; en = e; seed_in = s;
    for (int g = 0; g < 2; g++) begin
      if (!r) begin
        m_out[g] = 8'hBD; m_start[g] = 8'hBD;
        m_cnt[g] = 0; m_wrap[g] = 0; m_lock[g] = 0;
      end else if (l) begin
        m_out[g] = s; m_start[g] = s;
        m_cnt[g] = 0; m_wrap[g] = 0; m_lock[g] = 0;
      end else if (m_out[g] == 8'h00) begin
        m_out[g] = 8'hBD; m_start[g] = 8'hBD;
        m_cnt[g] = 0; m_wrap[g] = 0; m_lock[g] = 1;
      end else if (e) begin
        n = (g == 0) ? fib_next(m_out[g]) : gal_next(m_out[g]);
        m_out[g] = n;
        m_lock[g] = 0;
        if (n == m_start[g]) begin
          m_wrap[g] = 1; m_cnt[g] = 0;
        end else begin
          m_wrap[g] = 0; m_cnt[g] = m_cnt[g] + 8'd1;
        end
      end else begin
        m_wrap[g] = 0; m_lock[g] = 0;
      end
      x.out[g] = m_out[g]; x.cnt[g] = m_cnt[g];
      x.wrap[g] = m_wrap[g]; x.lock[g] = m_lock[g];
    end
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: compare both instances every driven cycle.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if ({f_out, f_cnt, f_wrap, f_lock} !==
          {x.out[0], x.cnt[0], x.wrap[0], x.lock[0]}) begin
        errors++;
        $display("FAIL sb_fib: got out=%h cnt=%0d wrap=%b lock=%b want out=%h cnt=%0d wrap=%b lock=%b",
                 f_out, f_cnt, f_wrap, f_lock,
                 x.out[0], x.cnt[0], x.wrap[0], x.lock[0]);
      end
      checks++;
      if ({g_out, g_cnt, g_wrap, g_lock} !==
          {x.out[1], x.cnt[1], x.wrap[1], x.lock[1]}) begin
        errors++;
        $display("FAIL sb_gal: got out=%h cnt=%0d wrap=%b lock=%b want out=%h cnt=%0d wrap=%b lock=%b",
                 g_out, g_cnt, g_wrap, g_lock,
                 x.out[1], x.cnt[1], x.wrap[1], x.lock[1]);
      end
    end
  end

  task automatic test_reset();
    drive(0, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h00);
    checks++;
    if ({f_out, f_cnt, f_wrap, f_lock} !== {8'hBD, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset_fib: got %h/%0d/%b/%b want BD/0/0/0",
               f_out, f_cnt, f_wrap, f_lock);
    end
    checks++;
    if ({g_out, g_cnt, g_wrap, g_lock} !== {8'hBD, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset_gal: got %h/%0d/%b/%b want BD/0/0/0",
               g_out, g_cnt, g_wrap, g_lock);
    end
    checks++;
    if (f_bit !== 1'b1) begin
      errors++;
      $display("FAIL reset_bit: got %b want 1", f_bit);
    end
  endtask

  task automatic test_first_steps();
    drive(1, 0, 1, 8'h00);
    checks++;
    if ({f_out, f_bit} !== {8'h7B, 1'b0}) begin
      errors++;
      $display("FAIL step1_fib: got %h bit %b want 7B bit 0", f_out, f_bit);
    end
    checks++;
    if (g_out !== 8'h67) begin
      errors++;
      $display("FAIL step1_gal: got %h want 67", g_out);
    end
    drive(1, 0, 1, 8'h00);
    checks++;
    if ({f_out, f_bit} !== {8'hF6, 1'b1}) begin
      errors++;
      $display("FAIL step2_fib: got %h bit %b want F6 bit 1", f_out, f_bit);
    end
  endtask

  task automatic test_full_period();
    drive(0, 0, 0, 8'h00);
    for (int k = 1; k <= 255; k++) begin
      drive(1, 0, 1, 8'h00);
      if (k == 254) begin
        checks++;
        if ({f_cnt, f_wrap, g_cnt, g_wrap} !== {8'd254, 1'b0, 8'd254, 1'b0}) begin
          errors++;
          $display("FAIL pre_wrap: got fib cnt=%0d wrap=%b gal cnt=%0d wrap=%b want 254/0",
                   f_cnt, f_wrap, g_cnt, g_wrap);
        end
      end
      if (k == 255) begin
        checks++;
        if ({f_out, f_cnt, f_wrap} !== {8'hBD, 8'd0, 1'b1}) begin
          errors++;
          $display("FAIL wrap_fib: got %h/%0d/%b want BD/0/1", f_out, f_cnt, f_wrap);
        end
        checks++;
        if ({g_out, g_cnt, g_wrap} !== {8'hBD, 8'd0, 1'b1}) begin
          errors++;
          $display("FAIL wrap_gal: got %h/%0d/%b want BD/0/1", g_out, g_cnt, g_wrap);
        end
      end
    end
    drive(1, 0, 0, 8'h00);
    checks++;
    if ({f_wrap, g_wrap} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_pulse: got %b%b want 00", f_wrap, g_wrap);
    end
  endtask

  task automatic test_zero_seed();
    drive(1, 1, 1, 8'h00);
    checks++;
    if ({f_out, g_out, f_lock} !== {8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL zero_load: got %h %h lock %b want 00 00 0", f_out, g_out, f_lock);
    end
    drive(1, 0, 1, 8'h00);
    checks++;
    if ({f_out, f_cnt, f_lock, f_wrap} !== {8'hBD, 8'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lockup: got %h/%0d/%b/%b want BD/0/1/0", f_out, f_cnt, f_lock, f_wrap);
    end
    checks++;
    if ({g_out, g_lock} !== {8'hBD, 1'b1}) begin
      errors++;
      $display("FAIL lockup_gal: got %h/%b want BD/1", g_out, g_lock);
    end
    drive(1, 0, 1, 8'h00);
    checks++;
    if ({f_out, f_lock} !== {8'h7B, 1'b0}) begin
      errors++;
      $display("FAIL lock_clear: got %h/%b want 7B/0", f_out, f_lock);
    end
  endtask

  task automatic test_load_priority();
    int first_wrap;
    first_wrap = 0;
    drive(1, 1, 1, 8'h01);
    checks++;
    if ({f_out, f_cnt, g_out, g_cnt} !== {8'h01, 8'd0, 8'h01, 8'd0}) begin
      errors++;
      $display("FAIL load_wins: got fib %h/%0d gal %h/%0d want 01/0",
               f_out, f_cnt, g_out, g_cnt);
    end
    for (int k = 1; k <= 255; k++) begin
      drive(1, 0, 1, 8'h00);
      if (f_wrap && first_wrap == 0) first_wrap = k;
    end
    checks++;
    if (first_wrap != 255 || f_out !== 8'h01 || g_out !== 8'h01) begin
      errors++;
      $display("FAIL load_period: got wrap step %0d out %h/%h want 255 01/01",
               first_wrap, f_out, g_out);
    end
  endtask

  task automatic test_random();
    logic [7:0] s;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        drive(1, 1, 1'($urandom), s);
      end else begin
        drive(1, 0, 1'($urandom), 8'h00);
      end
    end
    drive(0, 0, 1, 8'h00);
    checks++;
    if ({f_out, f_cnt, g_out, g_cnt} !== {8'hBD, 8'd0, 8'hBD, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset: got fib %h/%0d gal %h/%0d want BD/0",
               f_out, f_cnt, g_out, g_cnt);
    end
  endtask

  initial begin
    rst_n = 0; en = 0; load = 0; seed_in = 0;
    test_reset();
    test_first_steps();
    test_full_period();
    test_zero_seed();
    test_load_priority();
    test_random();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
